// File: rtl/flag_period_monitor_if.sv
// Signal bundle between a strobe source (master) and flag_period_monitor (slave).
// period_valid and err are single-cycle qualifiers with no ready/backpressure: a
// consumer must take period_out/err_cnt in the cycle the pulse is high.
// state_dbg encodes the monitor state as 0=IDLE, 1=ACQ, 2=LOCKED.
interface flag_period_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
);
    logic             clk_flag_in;
    logic             clear;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state_dbg;

    modport master (
        output clk_flag_in,
        output clear,
        input  period_out,
        input  period_valid,
        input  locked,
        input  err,
        input  err_cnt,
        input  state_dbg
    );

    modport slave (
        input  clk_flag_in,
        input  clear,
        output period_out,
        output period_valid,
        output locked,
        output err,
        output err_cnt,
        output state_dbg
    );
endinterface

// File: rtl/flag_period_monitor.sv
// Measures the gap between rising edges of a sys_clk-synchronous strobe, locks after
// LOCK_N good gaps and flags early/missing strobes. Define FLAG_MON_TOL_EN for a +/-TOL window.
module flag_period_monitor #(
    parameter int EXP_PERIOD = 6,
    parameter int CNT_W      = 8,
    parameter int LOCK_N     = 3,
    parameter int ERR_W      = 8,
    parameter int TOL        = 1
) (
    input logic                  sys_clk,
    input logic                  sys_rst_n,
    flag_period_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int GOOD_W = $clog2(LOCK_N + 1);

`ifdef FLAG_MON_TOL_EN
    localparam int TOL_EFF = TOL;
`else
    // Window collapses to an exact match; TOL is deliberately ignored.
    localparam int TOL_EFF = TOL * 0;
`endif

    localparam int WIN_LO_I = (EXP_PERIOD > TOL_EFF) ? (EXP_PERIOD - TOL_EFF) : 0;
    localparam int WIN_HI_I = EXP_PERIOD + TOL_EFF;

    localparam logic [31:0]       WIN_LO   = 32'(WIN_LO_I);
    localparam logic [31:0]       WIN_HI   = 32'(WIN_HI_I);
    localparam logic [CNT_W-1:0]  GCNT_MAX = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_N);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    gcnt_q, gcnt_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                locked_q;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic                in_d_q;

    logic                flag_edge;
    logic [31:0]         meas;
    logic                in_window;
    logic                miss;
    logic                err_event;
    logic [GOOD_W-1:0]   good_inc;

    assign flag_edge = mon.clk_flag_in & ~in_d_q;
    assign meas      = 32'(gcnt_q);
    assign in_window = (meas >= WIN_LO) && (meas <= WIN_HI);
    // Missing strobe: the latest acceptable edge time has arrived with no edge.
    assign miss      = (meas == WIN_HI) && !flag_edge;
    assign good_inc  = good_q + GOOD_W'(1);

    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        good_d    = good_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        err_event = 1'b0;

        if (state_q == IDLE) begin
            gcnt_d = '0;
        end else if (gcnt_q != GCNT_MAX) begin
            gcnt_d = gcnt_q + CNT_W'(1);
        end
        if (flag_edge) begin
            gcnt_d = CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                // First edge only establishes a reference; nothing to measure yet.
                if (flag_edge) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            ACQ: begin
                if (flag_edge) begin
                    period_d = gcnt_q;
                    valid_d  = 1'b1;
                    if (in_window) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (flag_edge) begin
                    period_d = gcnt_q;
                    valid_d  = 1'b1;
                    if (!in_window) begin
                        // Early strobe: it becomes the new reference for reacquisition.
                        err_event = 1'b1;
                        state_d   = ACQ;
                        good_d    = '0;
                    end
                end else if (miss) begin
                    err_event = 1'b1;
                    state_d   = IDLE;
                    gcnt_d    = '0;
                    good_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gcnt_d  = '0;
                good_d  = '0;
            end
        endcase

        if (err_event) begin
            err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end

        // Soft clear wins over any edge or error in the same cycle.
        if (mon.clear) begin
            state_d   = IDLE;
            gcnt_d    = '0;
            good_d    = '0;
            period_d  = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            gcnt_q    <= '0;
            good_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_cnt_q <= '0;
            in_d_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gcnt_q    <= gcnt_d;
            good_q    <= good_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            locked_q  <= (state_d == LOCKED);
            err_cnt_q <= err_cnt_d;
            in_d_q    <= mon.clk_flag_in;
        end
    end

    assign mon.period_out   = period_q;
    assign mon.period_valid = valid_q;
    assign mon.locked       = locked_q;
    assign mon.err          = err_q;
    assign mon.err_cnt      = err_cnt_q;
    assign mon.state_dbg    = state_q;

endmodule

// File: doc/flag_period_monitor.md
Name: flag_period_monitor

Overview:
- Receive-side checker for the single-cycle strobe produced by the team's clock-divider/flag generators.
- Detects rising edges of the strobe and measures the interval between them in sys_clk cycles.
- Declares lock after LOCK_N consecutive correct intervals, then flags lost or misplaced strobes.
- Sits in the same sys_clk domain as the strobe source. Used as a system-level health monitor and as a bench checker.

Parameters:
- EXP_PERIOD, 6, expected interval in cycles between strobe rising edges; legal range 2 to 2^CNT_W-2.
- CNT_W, 8, width of the gap counter and period_out.
- LOCK_N, 3, consecutive matching intervals required to enter LOCKED; must be ≥1.
- ERR_W, 8, width of err_cnt.
- TOL, 1, accepted deviation in cycles. Used only when FLAG_MON_TOL_EN is defined.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; asynchronous assert, active-low.
- clk_flag_in  in  1  strobe under test; synchronous to sys_clk.
- clear  in  1  synchronous soft clear; priority over all other events.
- period_out  out  CNT_W  last measured interval.
- period_valid  out  1  one-cycle pulse when period_out updates.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse on a detected error.
- err_cnt  out  ERR_W  saturating error count.

Interface rule (already decided): one clock, sys_clk; reset sys_rst_n is asynchronous and active-low.

Behaviour:
- Reset values: period_out=0, period_valid=0, locked=0, err=0, err_cnt=0, state=IDLE, gcnt=0, good_cnt=0, in_d=0.
- Edge detection: edge = clk_flag_in & ~in_d, where in_d is clk_flag_in registered. A strobe held high for N cycles counts as one edge.
- Gap counter gcnt:
  - On an edge, gcnt<=1.
  - Otherwise gcnt increments, saturating at 2^CNT_W-1.
  - A measurement is the value of gcnt in the edge cycle. With a strobe every 6 cycles, the measurement is 6.
- Match: measurement == EXP_PERIOD.
- Latency: period_out, period_valid, err, locked and err_cnt are all registered. Each updates on the clock edge that samples the triggering edge or condition, so it is visible one cycle after it.
- States:
  - IDLE: gcnt is held at 0. On the first edge, go to ACQ with good_cnt=0. No period_valid is produced (no reference edge yet).
  - ACQ: on each edge, period_out<=measurement and period_valid=1.
    - Match: good_cnt++. When good_cnt reaches LOCK_N, go to LOCKED.
    - Mismatch: good_cnt<=0, stay in ACQ, no err.
  - LOCKED: on each edge, period_out and period_valid update as in ACQ.
    - Mismatch edge (early strobe): err pulse, err_cnt++, go to ACQ with good_cnt=0. That edge becomes the new reference.
    - Missing strobe: if gcnt==EXP_PERIOD and there is no edge in that cycle, err pulse, err_cnt++, go to IDLE, no period_valid.
- locked is low in every state except LOCKED, and is deasserted in the same cycle err is asserted.
- err_cnt saturates at 2^ERR_W-1. Further errors still pulse err.
- clear (synchronous):
  - State goes to IDLE.
  - gcnt, good_cnt, period_out and err_cnt go to 0.
  - period_valid, err and locked go to 0.
  - An edge in the clear cycle is ignored. in_d still samples.
- A mid-operation sys_rst_n assert returns everything to reset values immediately. After release, the first edge only starts acquisition.

Optional Feature:
- Macro: FLAG_MON_TOL_EN.
- Defined: match means |measurement − EXP_PERIOD| ≤ TOL. The missing-strobe check fires at gcnt==EXP_PERIOD+TOL with no edge.
- Undefined: exact match only, and TOL is unused.

Test Plan:
1. Reset, then 1-cycle strobe every 6 cycles:
   - No period_valid after the 1st edge.
   - period_valid with period_out=6 after the 2nd edge.
   - locked=1 one cycle after the 4th edge.
   - err_cnt stays 0.
2. Locked, then one gap of 5:
   - period_out=5, err pulse, err_cnt=1, locked drops.
   - locked reasserts after 3 further gaps of 6.
3. Locked, then a strobe delayed to a gap of 9:
   - err pulses one cycle after the cycle where gcnt=6, and err_cnt increments.
   - The late edge gives no period_valid (state is IDLE).
   - Relock takes 4 further edges.
4. Strobe held high for 10 cycles, then gaps of 6 measured from its rising edge:
   - Only one edge is counted from the held-high pulse.
   - The first measurement is 6.
5. CNT_W=4, in ACQ, gap of 20: period_out=15 (saturated), no err.
6. Locked with err_cnt=2, then:
   - clear for 1 cycle: IDLE, locked=0, err_cnt=0.
   - Separately, sys_rst_n low mid-gap: all outputs return to 0 immediately.
